// File: rtl/gpr_scoreboard.sv
// Issue-stage GPR scoreboard: per-register in-flight counters for late writers gate IDU->EXU issue.
// Optional GPR_SCOREBOARD_PERF_EN adds stall/fire performance counters.
module gpr_scoreboard #(
  parameter int unsigned CNT_W = 2,
  parameter int unsigned NREG  = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [4:0]      iss_rs1,
  input  logic            iss_rs1_en,
  input  logic [4:0]      iss_rs2,
  input  logic            iss_rs2_en,
  input  logic [4:0]      iss_rd,
  input  logic            iss_late,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            cancel_valid,
  input  logic [4:0]      cancel_rd,
  output logic [NREG-1:0] busy,
  output logic            idle,
`ifdef GPR_SCOREBOARD_PERF_EN
  output logic            err,
  output logic [31:0]     perf_stall_raw,
  output logic [31:0]     perf_stall_full,
  output logic [31:0]     perf_fire
`else
  output logic            err
`endif
);

  localparam logic [CNT_W-1:0] CAP  = '1;
  localparam logic [CNT_W:0]   CAPW = {1'b0, CAP};

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             err_q, err_d;
  logic             raw1, raw2, full, fire;
  logic             inc, wb_hit, can_hit;
  logic [CNT_W:0]   up, dn, nv;

  always_comb begin
    busy = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      busy[i] = |cnt_q[i];
    end
  end

  assign idle = ~|busy;
  assign err  = err_q;

  // Hazards look only at registered counters, so a same-cycle writeback never releases a stall.
  assign raw1      = iss_rs1_en & (|iss_rs1) & busy[iss_rs1];
  assign raw2      = iss_rs2_en & (|iss_rs2) & busy[iss_rs2];
  assign full      = iss_late & (|iss_rd) & (cnt_q[iss_rd] == CAP);
  assign iss_ready = ~(raw1 | raw2 | full);
  assign fire      = iss_valid & iss_ready & iss_late & (|iss_rd);

  always_comb begin
    err_d    = err_q;
    cnt_d[0] = '0;
    inc      = 1'b0;
    wb_hit   = 1'b0;
    can_hit  = 1'b0;
    up       = '0;
    dn       = '0;
    nv       = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      inc     = fire & (iss_rd == 5'(i));
      wb_hit  = wb_valid & (wb_rd == 5'(i));
      can_hit = cancel_valid & (cancel_rd == 5'(i));
      up      = {1'b0, cnt_q[i]} + (CNT_W+1)'(inc);
      dn      = (CNT_W+1)'(wb_hit) + (CNT_W+1)'(can_hit);
      nv      = up - dn;
      // Net delta in [-2,+1]; saturate at both ends and flag the error.
      if (up < dn) begin
        cnt_d[i] = '0;
        err_d    = 1'b1;
      end else if (nv > CAPW) begin
        cnt_d[i] = CAP;
        err_d    = 1'b1;
      end else begin
        cnt_d[i] = nv[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) cnt_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
      err_q <= err_d;
    end
  end

`ifdef GPR_SCOREBOARD_PERF_EN
  logic [31:0] p_raw_q, p_full_q, p_fire_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      p_raw_q  <= '0;
      p_full_q <= '0;
      p_fire_q <= '0;
    end else begin
      if (iss_valid & (raw1 | raw2))          p_raw_q  <= p_raw_q + 32'd1;
      if (iss_valid & full & ~(raw1 | raw2))  p_full_q <= p_full_q + 32'd1;
      if (fire)                               p_fire_q <= p_fire_q + 32'd1;
    end
  end

  assign perf_stall_raw  = p_raw_q;
  assign perf_stall_full = p_full_q;
  assign perf_fire       = p_fire_q;
`endif

endmodule
